// File: rtl/data_memory_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_arbiter_pkg
// Description : Shared FSM encoding, memory window and counter constants for
//               the data memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package data_memory_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int unsigned C_MEM_BASE  = 1024;
  localparam int unsigned C_MEM_SIZE  = 256;
  localparam int          C_CNT_WIDTH = 4;
  localparam logic [C_CNT_WIDTH-1:0] C_CNT_MAX = '1;

  // True when a byte address falls inside the populated memory window.
  function automatic logic addr_in_range(input logic [31:0] byte_addr);
    return (byte_addr >= C_MEM_BASE) && (byte_addr < (C_MEM_BASE + C_MEM_SIZE));
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_memory_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_arbiter_if
// Description : Pipeline, secondary-requester and memory-port signals of the
//               data memory arbiter; slave = arbiter, master = surroundings.
// Revision    : 1.0 - initial release
// ============================================================================
interface data_memory_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  i_Pipe_Read_Enable;
  logic                  i_Pipe_Write_Enable;
  logic [DATA_WIDTH-1:0] i_Pipe_Address;
  logic [DATA_WIDTH-1:0] i_Pipe_Write_Data;
  logic [DATA_WIDTH-1:0] o_Pipe_Read_Data;
  logic                  o_Pipe_Stall;
  logic                  i_Sec_Request;
  logic                  i_Sec_Write;
  logic [DATA_WIDTH-1:0] i_Sec_Address;
  logic [DATA_WIDTH-1:0] i_Sec_Write_Data;
  logic                  o_Sec_Grant;
  logic [DATA_WIDTH-1:0] o_Sec_Read_Data;
  logic                  o_Sec_Read_Valid;
  logic                  o_Addr_Error;
  logic                  o_Mem_Write_Enable;
  logic                  o_Mem_Read_Enable;
  logic [DATA_WIDTH-1:0] o_Mem_Address;
  logic [DATA_WIDTH-1:0] o_Mem_Write_Data;
  logic [DATA_WIDTH-1:0] i_Mem_Read_Data;

  modport slave (
    input  i_Pipe_Read_Enable, i_Pipe_Write_Enable, i_Pipe_Address, i_Pipe_Write_Data,
    input  i_Sec_Request, i_Sec_Write, i_Sec_Address, i_Sec_Write_Data,
    input  i_Mem_Read_Data,
    output o_Pipe_Read_Data, o_Pipe_Stall,
    output o_Sec_Grant, o_Sec_Read_Data, o_Sec_Read_Valid, o_Addr_Error,
    output o_Mem_Write_Enable, o_Mem_Read_Enable, o_Mem_Address, o_Mem_Write_Data
  );

  modport master (
    output i_Pipe_Read_Enable, i_Pipe_Write_Enable, i_Pipe_Address, i_Pipe_Write_Data,
    output i_Sec_Request, i_Sec_Write, i_Sec_Address, i_Sec_Write_Data,
    output i_Mem_Read_Data,
    input  o_Pipe_Read_Data, o_Pipe_Stall,
    input  o_Sec_Grant, o_Sec_Read_Data, o_Sec_Read_Valid, o_Addr_Error,
    input  o_Mem_Write_Enable, o_Mem_Read_Enable, o_Mem_Address, o_Mem_Write_Data
  );

endinterface
`default_nettype wire

// File: rtl/data_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_arbiter
// Description : Shares the data memory between the MEM stage (default owner)
//               and a single-word secondary requester with starvation bound.
//               Optional range check: DATA_MEMORY_ARBITER_ADDR_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  data_memory_arbiter_if.slave bus
);

  state_t                  r_state;
  state_t                  w_state_next;
  logic [C_CNT_WIDTH-1:0]  r_cnt;
  logic [C_CNT_WIDTH-1:0]  w_cnt_next;
  logic                    w_pipe_active;
  logic                    w_grant;
  logic                    w_pipe_stall;
  logic                    w_raw_we;
  logic                    w_raw_re;
  logic                    w_addr_ok;
  logic [DATA_WIDTH-1:0]   w_mem_addr;
  logic [DATA_WIDTH-1:0]   w_mem_wdata;
  logic                    r_sec_read_valid;
  logic [DATA_WIDTH-1:0]   r_sec_read_data;

  always_comb begin
    w_pipe_active = bus.i_Pipe_Read_Enable | bus.i_Pipe_Write_Enable;
    w_grant       = (r_state == ST_WAIT) &&
                    (!w_pipe_active || (r_cnt == C_CNT_WIDTH'(STARVE_LIMIT)));
    w_pipe_stall  = w_grant & w_pipe_active;
  end

  // Memory port mux: the secondary owns the port only in its grant cycle.
  always_comb begin
    w_mem_addr  = bus.i_Pipe_Address;
    w_mem_wdata = bus.i_Pipe_Write_Data;
    w_raw_we    = bus.i_Pipe_Write_Enable;
    w_raw_re    = bus.i_Pipe_Read_Enable;
    if (w_grant) begin
      w_mem_addr  = bus.i_Sec_Address;
      w_mem_wdata = bus.i_Sec_Write_Data;
      w_raw_we    = bus.i_Sec_Write;
      w_raw_re    = !bus.i_Sec_Write;
    end
  end

`ifdef DATA_MEMORY_ARBITER_ADDR_CHECK_EN
  logic r_addr_err;

  assign w_addr_ok = addr_in_range(32'(w_mem_addr));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr_err <= 1'b0;
    end else begin
      r_addr_err <= (w_raw_we | w_raw_re) & !w_addr_ok;
    end
  end

  assign bus.o_Addr_Error = r_addr_err;
`else
  assign w_addr_ok        = 1'b1;
  assign bus.o_Addr_Error = 1'b0;
`endif

  assign bus.o_Mem_Address      = w_mem_addr;
  assign bus.o_Mem_Write_Data   = w_mem_wdata;
  assign bus.o_Mem_Write_Enable = w_raw_we & w_addr_ok;
  assign bus.o_Mem_Read_Enable  = w_raw_re & w_addr_ok;
  assign bus.o_Pipe_Stall       = w_pipe_stall;
  assign bus.o_Pipe_Read_Data   = (w_pipe_stall || !w_addr_ok) ? '0 : bus.i_Mem_Read_Data;
  assign bus.o_Sec_Grant        = w_grant;
  assign bus.o_Sec_Read_Data    = r_sec_read_data;
  assign bus.o_Sec_Read_Valid   = r_sec_read_valid;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_Sec_Request) w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_grant) begin
          w_state_next = ST_RESP;
          w_cnt_next   = '0;
        end else if (r_cnt != C_CNT_MAX) begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_RESP: begin
        w_state_next = bus.i_Sec_Request ? ST_WAIT : ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Read data is captured at the grant edge and held until the next read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sec_read_valid <= 1'b0;
      r_sec_read_data  <= '0;
    end else begin
      r_sec_read_valid <= w_grant & !bus.i_Sec_Write;
      if (w_grant && !bus.i_Sec_Write) begin
        r_sec_read_data <= w_addr_ok ? bus.i_Mem_Read_Data : '0;
      end
    end
  end

endmodule
`default_nettype wire
